// File: rtl/ucie_ctl_rx_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ucie_ctl_rx_flow_ctrl
// Description : UCIe RX flow controller. It sequences the RX buffer FSM
//               state request, tracks buffer occupancy, returns credits to
//               the TX side in batches and runs the overflow/link-down
//               drain-and-recover sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module ucie_ctl_rx_flow_ctrl #(
    parameter int DEPTH          = 16,
    parameter int CNT_W          = 5,
    parameter int CREDIT_BATCH   = 4,
    parameter int RECOVER_CYCLES = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_link_up,
    input  logic             i_flit_wr,
    input  logic             i_flit_rd,
    input  logic             i_overflow,
    input  logic             i_credit_ready,
    output logic [3:0]       o_state_request,
    output logic [CNT_W-1:0] o_occupancy,
    output logic             o_credit_valid,
    output logic [CNT_W-1:0] o_credit_count,
    output logic             o_err_overflow,
    output logic             o_err_underflow,
    output logic [3:0]       o_state
);

    localparam int DW_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    localparam logic [CNT_W-1:0] c_DEPTH       = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_BATCH       = CNT_W'(CREDIT_BATCH);
    localparam logic [CNT_W:0]   c_DEPTH_X     = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W:0]   c_BATCH_X     = (CNT_W+1)'(CREDIT_BATCH);
    localparam logic [DW_W-1:0]  c_DWELL_INIT  = DW_W'(RECOVER_CYCLES - 1);
    localparam logic [3:0]       c_REQ_ACTIVE  = 4'b0001;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_ACTIVE  = 4'b0010,
        ST_DRAIN   = 4'b0100,
        ST_RECOVER = 4'b1000
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] r_pend;
    logic             r_valid;
    logic [CNT_W-1:0] r_ccount;
    logic             r_err_ovf;
    logic             r_err_unf;
    logic [DW_W-1:0]  r_dwell;
    logic [3:0]       r_state_req;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_occ_nxt;
    logic [CNT_W-1:0] w_pend_nxt;
    logic             w_valid_nxt;
    logic             w_err_ovf_nxt;
    logic             w_err_unf_nxt;
    logic [DW_W-1:0]  w_dwell_nxt;
    logic             w_ovf;
    logic             w_wr_eff;
    logic             w_rd_cnt;
    logic             w_hs;
    logic [CNT_W:0]   w_pend_sum;

    // Next-state, occupancy, credit and error computation
    always_comb begin
        w_state_nxt   = r_state;
        w_occ_nxt     = r_occ;
        w_pend_nxt    = r_pend;
        w_valid_nxt   = r_valid;
        w_err_ovf_nxt = r_err_ovf;
        w_err_unf_nxt = r_err_unf;
        w_dwell_nxt   = r_dwell;
        w_ovf         = 1'b0;
        w_wr_eff      = 1'b0;
        w_rd_cnt      = 1'b0;
        w_hs          = 1'b0;
        w_pend_sum    = '0;
        case (r_state)
            ST_IDLE: begin
                w_occ_nxt   = '0;
                w_pend_nxt  = '0;
                w_valid_nxt = 1'b0;
                if (i_link_up) begin
                    w_state_nxt = ST_ACTIVE;
                    w_pend_nxt  = c_DEPTH;
                end
            end
            ST_ACTIVE: begin
                // A write into a full buffer without a draining read is an
                // overflow; the offending write is dropped, not counted.
                w_ovf    = i_overflow | (i_flit_wr & (r_occ == c_DEPTH) & ~i_flit_rd);
                w_wr_eff = i_flit_wr & ~w_ovf;
                if (w_wr_eff && !i_flit_rd) begin
                    w_occ_nxt = r_occ + 1'b1;
                end else if (i_flit_rd && !w_wr_eff) begin
                    if (r_occ == '0) begin
                        w_err_unf_nxt = 1'b1;
                    end else begin
                        w_occ_nxt = r_occ - 1'b1;
                        w_rd_cnt  = 1'b1;
                    end
                end else if (i_flit_rd && w_wr_eff) begin
                    w_rd_cnt = 1'b1;
                end
                // The offer only exists while valid is high, so pending is
                // always at least one batch when a handshake happens.
                w_hs       = r_valid & i_credit_ready;
                w_pend_sum = {1'b0, r_pend} + {{CNT_W{1'b0}}, w_rd_cnt}
                             - (w_hs ? c_BATCH_X : '0);
                w_pend_nxt = (w_pend_sum > c_DEPTH_X) ? c_DEPTH : w_pend_sum[CNT_W-1:0];
                if (w_hs) begin
                    w_valid_nxt = 1'b0;
                end else if (!r_valid && (r_pend >= c_BATCH)) begin
                    w_valid_nxt = 1'b1;
                end
                if (w_ovf) begin
                    w_err_ovf_nxt = 1'b1;
                    w_state_nxt   = ST_DRAIN;
                end else if (!i_link_up) begin
                    w_state_nxt = ST_DRAIN;
                end
                // Leaving ACTIVE aborts any outstanding offer.
                if (w_state_nxt != ST_ACTIVE) begin
                    w_valid_nxt = 1'b0;
                    w_pend_nxt  = '0;
                end
            end
            ST_DRAIN: begin
                w_valid_nxt = 1'b0;
                w_pend_nxt  = '0;
                if (i_flit_rd) begin
                    if (r_occ == '0) begin
                        w_err_unf_nxt = 1'b1;
                    end else begin
                        w_occ_nxt = r_occ - 1'b1;
                    end
                end
                if (r_occ == '0) begin
                    w_state_nxt = ST_RECOVER;
                    w_dwell_nxt = c_DWELL_INIT;
                end
            end
            ST_RECOVER: begin
                w_valid_nxt = 1'b0;
                w_pend_nxt  = '0;
                if (r_dwell == '0) begin
                    if (i_link_up) begin
                        w_state_nxt = ST_ACTIVE;
                        w_pend_nxt  = c_DEPTH;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_dwell_nxt = r_dwell - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_occ_nxt   = '0;
                w_pend_nxt  = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
        // Sticky errors are only released on the way into IDLE.
        if (w_state_nxt == ST_IDLE) begin
            w_err_ovf_nxt = 1'b0;
            w_err_unf_nxt = 1'b0;
        end
    end

    // State and output registers; reset overrides every sequence in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_occ       <= '0;
            r_pend      <= '0;
            r_valid     <= 1'b0;
            r_ccount    <= '0;
            r_err_ovf   <= 1'b0;
            r_err_unf   <= 1'b0;
            r_dwell     <= '0;
            r_state_req <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_occ       <= w_occ_nxt;
            r_pend      <= w_pend_nxt;
            r_valid     <= w_valid_nxt;
            r_ccount    <= w_valid_nxt ? c_BATCH : '0;
            r_err_ovf   <= w_err_ovf_nxt;
            r_err_unf   <= w_err_unf_nxt;
            r_dwell     <= w_dwell_nxt;
            r_state_req <= (w_state_nxt == ST_ACTIVE) ? c_REQ_ACTIVE : 4'b0000;
        end
    end

    assign o_state_request = r_state_req;
    assign o_occupancy     = r_occ;
    assign o_credit_valid  = r_valid;
    assign o_credit_count  = r_ccount;
    assign o_err_overflow  = r_err_ovf;
    assign o_err_underflow = r_err_unf;
    assign o_state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ucie_ctl_rx_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ucie_ctl_rx_flow_ctrl
// Description : Self-checking bench for ucie_ctl_rx_flow_ctrl. Directed
//               scenarios followed by a randomized run, all compared every
//               cycle against a behavioural model of the flow-control rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ucie_ctl_rx_flow_ctrl;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;
    localparam int B     = 4;
    localparam int RC    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, link_up, wr, rd, ovf, ready;
    logic [3:0]       o_state_request;
    logic [CNT_W-1:0] o_occupancy;
    logic             o_credit_valid;
    logic [CNT_W-1:0] o_credit_count;
    logic             o_err_overflow;
    logic             o_err_underflow;
    logic [3:0]       o_state;

    ucie_ctl_rx_flow_ctrl #(
        .DEPTH(DEPTH), .CNT_W(CNT_W), .CREDIT_BATCH(B), .RECOVER_CYCLES(RC)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_link_up      (link_up),
        .i_flit_wr      (wr),
        .i_flit_rd      (rd),
        .i_overflow     (ovf),
        .i_credit_ready (ready),
        .o_state_request(o_state_request),
        .o_occupancy    (o_occupancy),
        .o_credit_valid (o_credit_valid),
        .o_credit_count (o_credit_count),
        .o_err_overflow (o_err_overflow),
        .o_err_underflow(o_err_underflow),
        .o_state        (o_state)
    );

    int compared   = 0;
    int mismatched = 0;
    int obs_hs     = 0;

    // Behavioural model: 0 idle, 1 active, 2 drain, 3 recover
    int m_st, m_occ, m_pend, m_dwell;
    bit m_valid, m_eovf, m_eunf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int  nst, p, occ0;
        bit  ov, wok, cnt, hs;
        if (rst) begin
            m_st = 0; m_occ = 0; m_pend = 0; m_dwell = 0;
            m_valid = 0; m_eovf = 0; m_eunf = 0;
            return;
        end
        nst  = m_st;
        occ0 = m_occ;
        case (m_st)
            0: begin
                m_occ = 0; m_pend = 0; m_valid = 0;
                if (link_up) begin nst = 1; m_pend = DEPTH; end
            end
            1: begin
                ov  = ovf || (wr && m_occ == DEPTH && !rd);
                wok = wr && !ov;
                cnt = 0;
                if (rd && !wok && m_occ == 0) m_eunf = 1;
                else begin
                    m_occ = m_occ + int'(wok) - int'(rd);
                    cnt   = rd;
                end
                hs = m_valid && ready;
                p  = m_pend + int'(cnt) - (hs ? B : 0);
                if (hs) m_valid = 0;
                else if (!m_valid && m_pend >= B) m_valid = 1;
                m_pend = (p > DEPTH) ? DEPTH : p;
                if (ov) begin m_eovf = 1; nst = 2; end
                else if (!link_up) nst = 2;
                if (nst != 1) begin m_valid = 0; m_pend = 0; end
            end
            2: begin
                m_valid = 0; m_pend = 0;
                if (rd) begin
                    if (occ0 == 0) m_eunf = 1;
                    else m_occ = occ0 - 1;
                end
                if (occ0 == 0) begin nst = 3; m_dwell = RC; end
            end
            default: begin
                m_dwell--;
                if (m_dwell == 0) begin
                    if (link_up) begin nst = 1; m_pend = DEPTH; end
                    else nst = 0;
                end
            end
        endcase
        if (nst == 0) begin m_eovf = 0; m_eunf = 0; end
        m_st = nst;
    endtask

    // One clock: count DUT handshakes, advance model, compare all outputs.
    task automatic tick();
        if (!rst && o_credit_valid === 1'b1 && ready) obs_hs++;
        @(posedge clk);
        model_step();
        #1;
        check("state",     32'(o_state),         32'(1 << m_st));
        check("state_req", 32'(o_state_request), (m_st == 1) ? 32'd1 : 32'd0);
        check("occupancy", 32'(o_occupancy),     32'(m_occ));
        check("cr_valid",  32'(o_credit_valid),  32'(m_valid));
        check("cr_count",  32'(o_credit_count),  m_valid ? 32'(B) : 32'd0);
        check("err_ovf",   32'(o_err_overflow),  32'(m_eovf));
        check("err_unf",   32'(o_err_underflow), 32'(m_eunf));
    endtask

    initial begin
        rst = 1; link_up = 0; wr = 0; rd = 0; ovf = 0; ready = 0;
        tick(); tick();
        rst = 0;

        // T1: reset in the middle of ACTIVE with occupancy 5
        link_up = 1; tick();
        wr = 1; repeat (5) tick(); wr = 0;
        check("t1_pre_occ", 32'(o_occupancy), 32'd5);
        rst = 1; tick(); tick();
        check("t1_occ",   32'(o_occupancy),    32'd0);
        check("t1_state", 32'(o_state),        32'b0001);
        check("t1_valid", 32'(o_credit_valid), 32'd0);
        check("t1_errs",  32'({o_err_overflow, o_err_underflow}), 32'd0);
        rst = 0;

        // T2: initial credit grant drains as four batches
        ready = 1; obs_hs = 0;
        repeat (20) tick();
        check("t2_handshakes", 32'(obs_hs), 32'd4);
        check("t2_valid_end",  32'(o_credit_valid), 32'd0);

        // T3: read credits with the sink stalled, then released
        ready = 0;
        wr = 1; repeat (8) tick(); wr = 0;
        rd = 1; repeat (8) tick(); rd = 0;
        obs_hs = 0;
        repeat (3) begin
            tick();
            check("t3_hold_valid", 32'(o_credit_valid), 32'd1);
            check("t3_hold_count", 32'(o_credit_count), 32'(B));
        end
        ready = 1; repeat (6) tick(); ready = 0;
        check("t3_handshakes", 32'(obs_hs), 32'd2);
        check("t3_occ_end",    32'(o_occupancy), 32'd0);

        // T4: 17th write overflows; drain, recover, return to ACTIVE
        wr = 1; repeat (16) tick();
        check("t4_full", 32'(o_occupancy), 32'(DEPTH));
        tick(); wr = 0;
        check("t4_state_drain", 32'(o_state), 32'b0100);
        check("t4_err_ovf",     32'(o_err_overflow), 32'd1);
        check("t4_occ_kept",    32'(o_occupancy), 32'(DEPTH));
        rd = 1; repeat (16) tick(); rd = 0;
        check("t4_drained", 32'(o_occupancy), 32'd0);
        tick();
        check("t4_recover", 32'(o_state), 32'b1000);
        repeat (RC - 1) begin
            tick();
            check("t4_dwell", 32'(o_state), 32'b1000);
        end
        tick();
        check("t4_back_active", 32'(o_state), 32'b0010);

        // T5: link drop during an offer with occupancy 3
        wr = 1; repeat (3) tick(); wr = 0;
        check("t5_offer_up", 32'(o_credit_valid), 32'd1);
        check("t5_occ3",     32'(o_occupancy), 32'd3);
        link_up = 0; tick();
        check("t5_valid_abort", 32'(o_credit_valid), 32'd0);
        check("t5_drain",       32'(o_state), 32'b0100);
        rd = 1; repeat (3) tick(); rd = 0;
        tick();
        check("t5_recover", 32'(o_state), 32'b1000);
        repeat (RC) tick();
        check("t5_idle",     32'(o_state), 32'b0001);
        check("t5_err_clr",  32'(o_err_overflow), 32'd0);

        // T6: occupancy boundaries, underflow and external overflow
        link_up = 1; ready = 1; tick();
        wr = 1; rd = 1; tick();
        check("t6_wrrd_0",   32'(o_occupancy), 32'd0);
        check("t6_no_unf_0", 32'(o_err_underflow), 32'd0);
        rd = 0; repeat (16) tick();
        check("t6_full", 32'(o_occupancy), 32'(DEPTH));
        rd = 1; tick();
        check("t6_wrrd_16",   32'(o_occupancy), 32'(DEPTH));
        check("t6_no_ovf_16", 32'(o_err_overflow), 32'd0);
        wr = 0; repeat (16) tick();
        tick();
        check("t6_unf",      32'(o_err_underflow), 32'd1);
        check("t6_unf_occ",  32'(o_occupancy), 32'd0);
        rd = 0; ovf = 1; tick(); ovf = 0;
        check("t6_ovf_drain", 32'(o_state), 32'b0100);
        check("t6_ovf_flag",  32'(o_err_overflow), 32'd1);

        // Randomized run against the model
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 1500; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            link_up = ($urandom_range(0, 19) != 0);
            wr      = ($urandom_range(0, 1) == 1);
            rd      = ($urandom_range(0, 2) == 0) ? wr : ($urandom_range(0, 1) == 1);
            ovf     = ($urandom_range(0, 79) == 0);
            ready   = ($urandom_range(0, 1) == 1);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
